// File: rtl/ram_arbiter_if.sv
// Signal bundle between ram_arbiter (slave) and its command source, devices and RAM (master).
// Latency: none, wires only; all sequencing lives in ram_arbiter.
// Backpressure: commands use cmd_valid/cmd_ready; device and RAM lanes are never stalled.
interface ram_arbiter_if #(
  parameter int RAM_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_DEVICES = 4,
  parameter int DEV_W       = $clog2(NUM_DEVICES) + 1
);
  // command channel
  logic                              cmd_valid;
  logic [DEV_W-1:0]                  cmd_dev;
  logic                              cmd_ready;
  logic                              abort;
  // status
  logic                              busy;
  logic                              done;
  logic [DEV_W-1:0]                  done_dev;
  logic                              err;
  // device lanes
  logic [NUM_DEVICES-1:0]            dev_start;
  logic [NUM_DEVICES-1:0]            dev_finished;
  logic [NUM_DEVICES-1:0]            dev_we;
  logic [NUM_DEVICES*ADDR_WIDTH-1:0] dev_addr;
  logic [NUM_DEVICES*RAM_WIDTH-1:0]  dev_wdata;
  logic [RAM_WIDTH-1:0]              dev_rdata;
  // granted RAM port
  logic                              ram_we;
  logic [ADDR_WIDTH-1:0]             ram_addr;
  logic [RAM_WIDTH-1:0]              ram_wdata;
  logic [RAM_WIDTH-1:0]              ram_rdata;

  modport master (
    output cmd_valid, cmd_dev, abort, dev_finished, dev_we, dev_addr, dev_wdata, ram_rdata,
    input  cmd_ready, busy, done, done_dev, err, dev_start, dev_rdata, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  cmd_valid, cmd_dev, abort, dev_finished, dev_we, dev_addr, dev_wdata, ram_rdata,
    output cmd_ready, busy, done, done_dev, err, dev_start, dev_rdata, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Grants a single RAM port to one commanded device at a time, with abort and optional watchdog.
// Latency: command accepted at t, RUN at t+1, finished sampled at t+1 gives done at t+2.
// Backpressure: cmd_ready only in IDLE; commands offered in RUN/DONE are ignored, not queued.
module ram_arbiter #(
  parameter int RAM_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_DEVICES = 4,
  parameter int DEV_W       = $clog2(NUM_DEVICES) + 1,
  parameter int TIMEOUT     = 0
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Watchdog only needs to reach TIMEOUT-1; when disabled it just free-runs.
  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WDOG_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_LAST_I[WDOG_W-1:0];

  state_t                 r_state, w_state_nxt;
  logic [DEV_W-1:0]       r_sel, w_sel_nxt;
  logic [WDOG_W-1:0]      r_wdog, w_wdog_nxt;
  logic [DEV_W-1:0]       r_done_dev, w_done_dev_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_ready_en;

  logic                   w_run;
  logic                   w_cmd_ready;
  logic                   w_cmd_ok;
  logic                   w_fin_sel;
  logic                   w_timeout;
  logic [NUM_DEVICES-1:0] w_onehot;
  logic                   w_we_sel;
  logic [ADDR_WIDTH-1:0]  w_addr_sel;
  logic [RAM_WIDTH-1:0]   w_wdata_sel;

  assign w_run       = (r_state == S_RUN);
  // r_ready_en keeps cmd_ready low until the first clock after reset release.
  assign w_cmd_ready = (r_state == S_IDLE) && r_ready_en;
  assign w_cmd_ok    = (bus.cmd_dev < DEV_W'(NUM_DEVICES));
  assign w_fin_sel   = |(bus.dev_finished & w_onehot);
  assign w_timeout   = (TIMEOUT > 0) && (r_wdog == WDOG_LAST);

  // Decode sel into a one-hot mask and mux the selected device's RAM request.
  always_comb begin
    w_onehot    = '0;
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      w_onehot[i] = (r_sel == DEV_W'(i));
      if (w_onehot[i]) begin
        w_addr_sel  = w_addr_sel  | bus.dev_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata_sel = w_wdata_sel | bus.dev_wdata[i*RAM_WIDTH +: RAM_WIDTH];
      end
    end
    w_we_sel = |(bus.dev_we & w_onehot);
  end

  // Next-state logic: abort beats finished, finished beats the watchdog.
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_wdog_nxt     = r_wdog;
    w_done_dev_nxt = r_done_dev;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && w_cmd_ready) begin
          if (w_cmd_ok) begin
            w_sel_nxt   = bus.cmd_dev;
            w_wdog_nxt  = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        w_wdog_nxt = r_wdog + WDOG_W'(1);
        if (bus.abort) begin
          w_state_nxt    = S_DONE;
          w_done_nxt     = 1'b1;
          w_err_nxt      = 1'b1;
          w_done_dev_nxt = r_sel;
        end else if (w_fin_sel) begin
          w_state_nxt    = S_DONE;
          w_done_nxt     = 1'b1;
          w_done_dev_nxt = r_sel;
        end else if (w_timeout) begin
          w_state_nxt    = S_DONE;
          w_done_nxt     = 1'b1;
          w_err_nxt      = 1'b1;
          w_done_dev_nxt = r_sel;
        end
      end
      S_DONE: begin
        // Wait for the device to drop finished so it cannot retrigger a new run.
        if (!w_fin_sel) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and status registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_wdog     <= '0;
      r_done_dev <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_wdog     <= w_wdog_nxt;
      r_done_dev <= w_done_dev_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_ready_en <= 1'b1;
    end
  end

  // Grant outputs are gated by RUN so reset drops them without a clock edge.
  assign bus.cmd_ready = w_cmd_ready;
  assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.done_dev  = r_done_dev;
  assign bus.dev_start = w_run ? w_onehot : '0;
  assign bus.ram_we    = w_run & w_we_sel;
  assign bus.ram_addr  = w_run ? w_addr_sel : '0;
  assign bus.ram_wdata = w_run ? w_wdata_sel : '0;
  assign bus.dev_rdata = bus.ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with 3 devices and a 16-cycle watchdog.
// Stimulus computes each command's outcome from event timing and queues it; a monitor checks done/err.
// Per-cycle checks cover grant muxing, reset behaviour and the ready/busy protocol.
module tb_ram_arbiter;
  localparam int NDEV = 3;
  localparam int TOUT = 16;

  typedef struct {
    logic       done;
    logic       err;
    logic [2:0] dev;
    int         cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t sb_q[$];
  exp_t m_e;
  logic [2:0] last_dev;

  ram_arbiter_if #(.RAM_WIDTH(8), .ADDR_WIDTH(8), .NUM_DEVICES(NDEV)) bus ();

  ram_arbiter #(
    .RAM_WIDTH(8), .ADDR_WIDTH(8), .NUM_DEVICES(NDEV), .TIMEOUT(TOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && (bus.done || bus.err)) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: done=%0b err=%0b at cycle %0d, expected no pulse",
                 bus.done, bus.err, cyc);
      end else begin
        m_e = sb_q.pop_front();
        chk("sb_done", 32'(bus.done), 32'(m_e.done));
        chk("sb_err", 32'(bus.err), 32'(m_e.err));
        chk("sb_done_dev", 32'(bus.done_dev), 32'(m_e.dev));
        chk("sb_cycle", 32'(cyc), 32'(m_e.cyc));
      end
    end
  end

  // One command: f = RUN cycle where finished rises (0 none), a = abort cycle (0 none).
  task automatic run_cmd(input int d, input int f, input int a, input bit fixed);
    int   r_len;
    int   n;
    logic e_err;
    exp_t e;
    logic       we_v;
    logic [7:0] addr_v;
    logic [7:0] data_v;
    chk("idle_ready", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_dev   = 3'(d);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = cyc;
    if (d >= NDEV) begin
      e.done = 1'b0; e.err = 1'b1; e.dev = last_dev; e.cyc = n;
      sb_q.push_back(e);
      chk("bad_ready", 32'(bus.cmd_ready), 1);
      chk("bad_start", 32'(bus.dev_start), 0);
      chk("bad_busy", 32'(bus.busy), 0);
      return;
    end
    // Earliest event ends the run; abort wins ties, finished beats the watchdog.
    r_len = TOUT;
    if (f != 0 && f < r_len) r_len = f;
    if (a != 0 && a < r_len) r_len = a;
    e_err = (a == r_len) || (f != r_len);
    e.done = 1'b1; e.err = e_err; e.dev = 3'(d); e.cyc = n + r_len;
    sb_q.push_back(e);
    last_dev = 3'(d);
    for (int c = 1; c <= r_len; c++) begin
      bus.dev_we    = 3'($urandom);
      bus.dev_addr  = 24'($urandom);
      bus.dev_wdata = 24'($urandom);
      if (fixed) begin
        bus.dev_we[d]          = 1'b1;
        bus.dev_addr[d*8 +: 8]  = 8'h05;
        bus.dev_wdata[d*8 +: 8] = 8'hA5;
      end
      we_v   = bus.dev_we[d];
      addr_v = bus.dev_addr[d*8 +: 8];
      data_v = bus.dev_wdata[d*8 +: 8];
      bus.cmd_valid       = 1'($urandom);
      bus.cmd_dev         = 3'($urandom);
      bus.dev_finished    = ($urandom % 2 == 1) ? 3'b111 : 3'b000;
      bus.dev_finished[d] = (c == f);
      bus.abort           = (c == a);
      bus.ram_rdata       = 8'($urandom);
      #1;
      chk("run_start", 32'(bus.dev_start), 32'(1 << d));
      chk("run_busy", 32'(bus.busy), 1);
      chk("run_ready", 32'(bus.cmd_ready), 0);
      chk("run_we", 32'(bus.ram_we), 32'(we_v));
      chk("run_addr", 32'(bus.ram_addr), 32'(addr_v));
      chk("run_wdata", 32'(bus.ram_wdata), 32'(data_v));
      chk("rdata_bcast", 32'(bus.dev_rdata), 32'(bus.ram_rdata));
      @(posedge clk); #1;
    end
    bus.abort     = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("done_busy", 32'(bus.busy), 1);
    chk("done_start", 32'(bus.dev_start), 0);
    chk("done_we", 32'(bus.ram_we), 0);
    chk("done_addr", 32'(bus.ram_addr), 0);
    chk("done_ready", 32'(bus.cmd_ready), 0);
    if (bus.dev_finished[d]) begin
      repeat ($urandom % 3) begin
        @(posedge clk); #1;
        chk("hold_busy", 32'(bus.busy), 1);
      end
    end
    bus.dev_finished = '0;
    @(posedge clk); #1;
    chk("back_idle_ready", 32'(bus.cmd_ready), 1);
    chk("back_idle_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    last_dev = '0;
    reset = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_dev = '0; bus.abort = 1'b0;
    bus.dev_finished = '0; bus.dev_we = '0; bus.dev_addr = '0; bus.dev_wdata = '0;
    bus.ram_rdata = '0;
    #3;
    chk("rst_ready", 32'(bus.cmd_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_done_dev", 32'(bus.done_dev), 0);
    chk("rst_start", 32'(bus.dev_start), 0);
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    #9 reset = 1'b1;
    #1 chk("rel_ready_before_edge", 32'(bus.cmd_ready), 0);
    @(posedge clk); #1;
    chk("rel_ready_after_edge", 32'(bus.cmd_ready), 1);

    // Directed scenarios.
    run_cmd(1, 4, 0, 1'b1);   // fixed write 0x05/0xA5, finished at RUN cycle 4
    run_cmd(3, 0, 0, 1'b0);   // invalid index
    run_cmd(7, 0, 0, 1'b0);   // invalid index, top of range
    run_cmd(2, 7, 0, 1'b0);   // other devices' finished noise ignored
    run_cmd(0, 5, 5, 1'b0);   // abort and finished together
    run_cmd(1, 16, 0, 1'b0);  // finished on the watchdog cycle wins
    run_cmd(0, 1, 0, 1'b0);   // minimum latency
    run_cmd(2, 0, 0, 1'b0);   // watchdog expiry

    // Reset during RUN cycle 3.
    bus.dev_we = 3'b111; bus.dev_finished = '0;
    bus.cmd_valid = 1'b1; bus.cmd_dev = 3'd2;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_start", 32'(bus.dev_start), 32'h4);
    chk("mid_we", 32'(bus.ram_we), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_start", 32'(bus.dev_start), 0);
    chk("arst_we", 32'(bus.ram_we), 0);
    chk("arst_addr", 32'(bus.ram_addr), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_ready", 32'(bus.cmd_ready), 0);
    chk("arst_done_dev", 32'(bus.done_dev), 0);
    last_dev = '0;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1 chk("rerel_ready_before_edge", 32'(bus.cmd_ready), 0);
    @(posedge clk); #1;
    chk("rerel_ready_after_edge", 32'(bus.cmd_ready), 1);
    bus.dev_we = '0;

    // Randomized commands.
    for (int k = 0; k < 60; k++) begin
      int d;
      int f;
      int a;
      d = $urandom % 4;
      f = ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 20));
      a = ($urandom % 3 == 0) ? int'($urandom_range(1, 20)) : 0;
      run_cmd(d, f, a, 1'b0);
    end

    repeat (2) begin @(posedge clk); #1; end
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
